button_conditioner: RTL



---
 rtl/clock_pkg.sv | 28 ++
 rtl/sync2.sv | 25 ++
 rtl/button_conditioner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-end: button FSM states, the
// system clock rate and the timing defaults derived from it.
package clock_pkg;

  localparam int unsigned CLK_HZ        = 27_000_000;
  localparam int unsigned DEBOUNCE      = CLK_HZ / 125;  // 8 ms
  localparam int unsigned REPEAT_DELAY  = CLK_HZ / 2;    // 500 ms
  localparam int unsigned REPEAT_PERIOD = CLK_HZ / 10;   // 100 ms

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HOLD,
    REPEAT,
    RELEASE_DB
  } btn_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
module sync2 #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; both stages reset to the caller's idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a bouncing pin, debounces press and
// release, and emits single-cycle step pulses with optional auto-repeat.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = clock_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = clock_pkg::REPEAT_PERIOD,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic pressed,
  output logic step_pulse,
  output logic repeating
);

  localparam int unsigned CNT_MAX = clock_pkg::max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                   btn_sync;
  logic                   active;
  logic [CW-1:0]          cnt;
  clock_pkg::btn_state_t  state;

  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign active = ACTIVE_LOW ? ~btn_sync : btn_sync;

  // Press/hold/repeat/release sequencing with one shared timing counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= clock_pkg::IDLE;
      cnt        <= '0;
      pressed    <= 1'b0;
      step_pulse <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        clock_pkg::IDLE: begin
          if (active) begin
            state <= clock_pkg::PRESS_DB;
            cnt   <= '0;
          end
        end

        clock_pkg::PRESS_DB: begin
          if (!active) begin
            state <= clock_pkg::IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state      <= clock_pkg::HOLD;
            cnt        <= '0;
            pressed    <= 1'b1;
            step_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        clock_pkg::HOLD: begin
          if (!active) begin
            state <= clock_pkg::RELEASE_DB;
            cnt   <= '0;
          end else if (!repeat_en) begin
            cnt <= '0;
          end else if (cnt == RD_LAST) begin
            state      <= clock_pkg::REPEAT;
            cnt        <= '0;
            step_pulse <= 1'b1;
            repeating  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        clock_pkg::REPEAT: begin
          if (!active) begin
            state     <= clock_pkg::RELEASE_DB;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (!repeat_en) begin
            state     <= clock_pkg::HOLD;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (cnt == RP_LAST) begin
            cnt        <= '0;
            step_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        clock_pkg::RELEASE_DB: begin
          // A bounce back to active returns to HOLD silently: no new pulse.
          if (active) begin
            state <= clock_pkg::HOLD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= clock_pkg::IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state     <= clock_pkg::IDLE;
          cnt       <= '0;
          pressed   <= 1'b0;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule
